// File: rtl/audio_pkg.sv
// Shared audio types for the I2S transmitter, receiver and mixer.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_sample_t;

    localparam logic I2S_LEFT = 1'b0;

endpackage

// File: rtl/i2s_input_sync.sv
// Synchronizes the asynchronous I2S bus into the clk domain and flags bclk rising edges.
module i2s_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bclk_i,
    input  logic lrclk_i,
    input  logic din_i,
    output logic bclk_rise_o,
    output logic lrclk_s_o,
    output logic din_s_o
);

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   bclk_prev_q;
    logic                   bclk_rise_q;
    logic                   lrclk_q;
    logic                   din_q;

    // Edge flag is registered together with lrclk/din so all three stay aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            din_sync_q   <= '0;
            bclk_prev_q  <= 1'b0;
            bclk_rise_q  <= 1'b0;
            lrclk_q      <= 1'b0;
            din_q        <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk_i};
            lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk_i};
            din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], din_i};
            bclk_prev_q  <= bclk_sync_q[SYNC_STAGES-1];
            bclk_rise_q  <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
            lrclk_q      <= lrclk_sync_q[SYNC_STAGES-1];
            din_q        <= din_sync_q[SYNC_STAGES-1];
        end
    end

    assign bclk_rise_o = bclk_rise_q;
    assign lrclk_s_o   = lrclk_q;
    assign din_s_o     = din_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S bus slave: deserializes left/right words and presents stereo pairs on valid/ready.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_din,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    output logic                    locked
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] SW_C = CW'(SAMPLE_WIDTH);

    // Short words arrive right-aligned in the shifter; move them to the MSBs.
    function automatic logic [SAMPLE_WIDTH-1:0] left_justify(
        input logic [SAMPLE_WIDTH-1:0] val,
        input logic [CW-1:0]           n
    );
        logic [SAMPLE_WIDTH-1:0] res;
        if (n == '0) begin
            res = '0;
        end else begin
            res = val << (SW_C - n);
        end
        return res;
    endfunction

    logic bclk_rise_s;
    logic lrclk_s;
    logic din_s;

    i2s_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk),
        .rst_i      (rst),
        .bclk_i     (i2s_bclk),
        .lrclk_i    (i2s_lrclk),
        .din_i      (i2s_din),
        .bclk_rise_o(bclk_rise_s),
        .lrclk_s_o  (lrclk_s),
        .din_s_o    (din_s)
    );

    logic                    lr_q,         lr_d;
    logic [CW-1:0]           bit_cnt_q,    bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_l_q,    shift_l_d;
    logic [SAMPLE_WIDTH-1:0] shift_r_q,    shift_r_d;
    logic [SAMPLE_WIDTH-1:0] word_l_q,     word_l_d;
    logic                    locked_q,     locked_d;
    logic                    frame_pend_q, frame_pend_d;
    logic [SAMPLE_WIDTH-1:0] pend_l_q,     pend_l_d;
    logic [SAMPLE_WIDTH-1:0] pend_r_q,     pend_r_d;
    logic [SAMPLE_WIDTH-1:0] left_q,       left_d;
    logic [SAMPLE_WIDTH-1:0] right_q,      right_d;
    logic                    valid_q,      valid_d;
    logic                    overrun_q,    overrun_d;

    logic [SAMPLE_WIDTH-1:0] cur_sh_s;
    logic [SAMPLE_WIDTH-1:0] new_sh_s;
    logic [CW-1:0]           n_bits_s;
    logic [SAMPLE_WIDTH-1:0] word_s;
    logic                    take_bit_s;

    // Shifter content after the current bit; bits past SAMPLE_WIDTH are dropped.
    always_comb begin
        cur_sh_s   = (lr_q == I2S_LEFT) ? shift_l_q : shift_r_q;
        take_bit_s = (bit_cnt_q < SW_C);
        if (take_bit_s) begin
            new_sh_s = {cur_sh_s[SAMPLE_WIDTH-2:0], din_s};
            n_bits_s = bit_cnt_q + CW'(1);
        end else begin
            new_sh_s = cur_sh_s;
            n_bits_s = bit_cnt_q;
        end
        word_s = left_justify(new_sh_s, n_bits_s);
    end

    // Bit counter, channel shifters and word finalization at lrclk changes.
    always_comb begin
        lr_d         = lr_q;
        bit_cnt_d    = bit_cnt_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
        word_l_d     = word_l_q;
        locked_d     = locked_q;
        frame_pend_d = 1'b0;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        if (bclk_rise_s) begin
            lr_d = lrclk_s;
            if (lr_q == I2S_LEFT) begin
                shift_l_d = new_sh_s;
            end else begin
                shift_r_d = new_sh_s;
            end
            if (lrclk_s == lr_q) begin
                bit_cnt_d = n_bits_s;
            end else begin
                bit_cnt_d = '0;
                if (lr_q == I2S_LEFT) begin
                    word_l_d = word_s;
                end else if (locked_q) begin
                    frame_pend_d = 1'b1;
                    pend_l_d     = word_l_q;
                    pend_r_d     = word_s;
                end else begin
                    locked_d = 1'b1;
                end
            end
        end else begin
            lr_d = lr_q;
        end
    end

    // Output holding register: a frame arriving while the pair is stalled is dropped.
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (frame_pend_q) begin
            if (!valid_q || sample_ready) begin
                left_d  = pend_l_q;
                right_d = pend_r_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_q         <= I2S_LEFT;
            bit_cnt_q    <= '0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
            word_l_q     <= '0;
            locked_q     <= 1'b0;
            frame_pend_q <= 1'b0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            lr_q         <= lr_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            word_l_q     <= word_l_d;
            locked_q     <= locked_d;
            frame_pend_q <= frame_pend_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: randomized I2S frames against a word-level model.
`timescale 1ns/1ps
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_din = 1'b0;
    logic        sample_ready = 1'b0;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        overrun;
    logic        locked;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_ovr = 0;
    int   ovr_cycles = 0;
    bit   model_locked = 1'b0;
    bit   ready_rand = 1'b0;
    logic ready_fixed = 1'b1;

    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    int          exp_lat[$];

    i2s_receiver #(
        .SAMPLE_WIDTH(16),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_din     (i2s_din),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Receiver view of an n-bit MSB-first word: first 16 bits kept, short words zero-padded.
    function automatic logic [15:0] model_word(input logic [31:0] v, input int n);
        logic [63:0] w;
        if (n >= 16) w = 64'(v) >> (n - 16);
        else         w = 64'(v) << (16 - n);
        return w[15:0];
    endfunction

    // One I2S slot: lrclk flips together with the LSB (one-bit delay), bclk = clk/8.
    task automatic send_slot(input logic ch, input logic [31:0] val, input int n,
                             input int start, input int stop, input bit mark);
        for (int k = start; k < stop; k++) begin
            i2s_bclk  = 1'b0;
            i2s_lrclk = (k == n - 1) ? ~ch : ch;
            i2s_din   = val[n-1-k];
            repeat (4) @(negedge clk);
            i2s_bclk = 1'b1;
            if (mark && k == n - 1) exp_lat.push_back(cyc + 5);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit drop);
        bit emit;
        emit = model_locked && !drop;
        if (!model_locked) begin
            model_locked = 1'b1;
        end else if (drop) begin
            exp_ovr++;
        end else begin
            exp_l.push_back(model_word(l, n));
            exp_r.push_back(model_word(r, n));
        end
        send_slot(1'b0, l, n, 0, n, 1'b0);
        send_slot(1'b1, r, n, 0, n, emit);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            sample_ready = ready_rand ? (($urandom & 1) != 0) : ready_fixed;
        end
    end

    // Latency of every valid rise and overrun pulse width.
    initial begin
        logic pv;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (overrun === 1'b1) ovr_cycles++;
            if (sample_valid === 1'b1 && !pv) begin
                if (exp_lat.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: valid rose at cycle %0d, none expected", cyc);
                end else begin
                    check("latency", cyc, exp_lat.pop_front());
                end
            end
            pv = sample_valid;
        end
    end

    // Handshake monitor: pops the scoreboard on each accepted pair and checks hold stability.
    initial begin
        logic        held;
        logic [15:0] hl;
        logic [15:0] hr;
        held = 1'b0;
        hl   = '0;
        hr   = '0;
        forever begin
            @(negedge clk);
            if (held) begin
                check("hold_valid", {31'd0, sample_valid}, 32'd1);
                check("hold_data", {left_sample, right_sample}, {hl, hr});
            end
            if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
                if (exp_l.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pair: got %h/%h, scoreboard empty", left_sample, right_sample);
                end else begin
                    check("left_sample", {16'd0, left_sample}, {16'd0, exp_l.pop_front()});
                    check("right_sample", {16'd0, right_sample}, {16'd0, exp_r.pop_front()});
                end
            end
            held = (sample_valid === 1'b1) && (sample_ready !== 1'b1);
            hl   = left_sample;
            hr   = right_sample;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        logic [31:0] l;
        logic [31:0] r;
        int          n;

        // Reset with the bus toggling.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i2s_bclk  = ~i2s_bclk;
            i2s_lrclk = ~i2s_lrclk;
            i2s_din   = ($urandom & 1) != 0;
        end
        @(negedge clk);
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b0;
        @(posedge clk);
        #1;
        check("rst_left", {16'd0, left_sample}, 32'd0);
        check("rst_right", {16'd0, right_sample}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_locked = 1'b0;
        repeat (4) @(negedge clk);

        // First frame only locks.
        send_frame(32'h5555, 32'hAAAA, 16, 1'b0);
        repeat (10) @(negedge clk);
        check("locked_after_first", {31'd0, locked}, 32'd1);

        // Basic frame.
        send_frame(32'h1234, 32'hABCD, 16, 1'b0);
        repeat (20) @(negedge clk);

        // Backpressure: second frame dropped with one overrun pulse.
        ready_fixed = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(32'h1111, 32'h2222, 16, 1'b0);
        send_frame(32'h3333, 32'h4444, 16, 1'b1);
        repeat (10) @(negedge clk);
        check("bp_valid", {31'd0, sample_valid}, 32'd1);
        check("bp_data", {left_sample, right_sample}, 32'h1111_2222);
        check("bp_overrun", ovr_cycles, 1);
        ready_fixed = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_valid_cleared", {31'd0, sample_valid}, 32'd0);

        // Long and short slots.
        send_frame(32'h123456, 32'hFEDCBA, 24, 1'b0);
        send_frame(32'hA5, 32'h3C, 8, 1'b0);
        repeat (20) @(negedge clk);

        // Reset halfway through a left word.
        send_slot(1'b0, 32'h5A5A, 16, 0, 8, 1'b0);
        rst = 1'b1;
        i2s_bclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_locked = 1'b0;
        @(negedge clk);
        check("relock_cleared", {31'd0, locked}, 32'd0);
        send_slot(1'b0, 32'h5A5A, 16, 8, 16, 1'b0);
        send_slot(1'b1, 32'h1234, 16, 0, 16, 1'b0);
        model_locked = 1'b1;
        repeat (10) @(negedge clk);
        check("relocked", {31'd0, locked}, 32'd1);
        send_frame(32'h0F0F, 32'hF0F0, 16, 1'b0);
        repeat (20) @(negedge clk);

        // Randomized frames with random ready.
        ready_rand = 1'b1;
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(32, 8);
            m = (64'd1 << n) - 64'd1;
            l = $urandom & m[31:0];
            r = $urandom & m[31:0];
            send_frame(l, r, n, 1'b0);
        end
        ready_rand = 1'b0;
        ready_fixed = 1'b1;
        repeat (40) @(negedge clk);

        check("scoreboard_drained", exp_l.size(), 0);
        check("latency_drained", exp_lat.size(), 0);
        check("overrun_total", ovr_cycles, exp_ovr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Serial-to-parallel I2S receiver, the inbound counterpart of the Audiosystem's I2S transmitter (audio_bclk / audio_lrclk / audio_dout).
- Runs in the system clock domain and oversamples an externally driven I2S bus (bus slave; it never drives bclk or lrclk).
- Assembles each left/right frame into a stereo sample pair and presents it on a valid/ready interface.
- Used as a loopback checker for the audio output path and as the future line/mic input front end.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel presented at the output.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizers (minimum 2).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- i2s_bclk  in  1  serial bit clock, asynchronous to clk.
- i2s_lrclk  in  1  word select: 0 = left, 1 = right. Asynchronous.
- i2s_din  in  1  serial data, MSB first. Asynchronous.
- left_sample  out  SAMPLE_WIDTH  left word of the completed frame.
- right_sample  out  SAMPLE_WIDTH  right word of the completed frame.
- sample_valid  out  1  a stereo pair is held on left_sample and right_sample.
- sample_ready  in  1  consumer accepts the pair.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- locked  out  1  the first right→left boundary has been seen since reset.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - left_sample=0, right_sample=0, sample_valid=0, overrun=0, locked=0.
  - Synchronizers, shifters and bit counter cleared.
  - Takes effect mid-frame; any partial frame is discarded.
- Input conditioning:
  - All three inputs pass through SYNC_STAGES flops.
  - A bclk rising edge is detected when sync_bclk=1 and the previous sync_bclk=0 (one extra register).
- Timing constraint: clk ≥ 4× bclk frequency, i.e. each bclk half-period is at least 2 clk cycles. Behaviour outside this is undefined.
- Per bclk rising edge, sample din and lrclk; lr_q holds the lrclk value from the previous bclk edge.
- Case lrclk == lr_q (within a word):
  - If bit_cnt < SAMPLE_WIDTH, shift din into the shifter of channel lr_q, then bit_cnt++.
  - Once bit_cnt reaches SAMPLE_WIDTH, further bits are dropped (extra LSBs truncated).
  - bit_cnt saturates.
- Case lrclk != lr_q (word boundary, standard I2S one-bit delay; this edge carries the LSB of the old word):
  - Shift din into channel lr_q's shifter if bit_cnt < SAMPLE_WIDTH.
  - Finalize the word. If fewer than SAMPLE_WIDTH bits were received, left-justify and zero-pad the LSBs.
  - Reset bit_cnt to 0.
  - The next bclk edge carries the MSB of the new channel.
- Frame completion happens on the right→left boundary (lr_q=1, lrclk=0):
  - If locked=0: set locked=1, discard the pair and emit nothing. The first partial frame is always dropped.
  - If locked=1 and (sample_valid=0 or sample_ready=1): on the next clk edge load left_sample and right_sample, and set sample_valid=1.
  - If locked=1 and sample_valid=1 and sample_ready=0: keep the held pair unchanged, drop the new pair, and pulse overrun for exactly 1 cycle.
- Handshake:
  - The pair transfers on a clk edge where sample_valid && sample_ready.
  - sample_valid clears after the transfer unless a new frame completes in the same cycle, in which case it stays 1 and the new pair is loaded.
  - Output data is stable while valid && !ready.
- Latency: sample_valid rises exactly SYNC_STAGES+2 clk cycles after the first clk edge at which raw i2s_bclk is sampled high for the boundary bit.
- A left→right boundary only finalizes the left word; it produces no output.

Decomposition:
- audio_pkg (shared):
  - typedef sample_t = logic signed [15:0].
  - struct stereo_sample_t {left, right}.
  - localparam I2S_LEFT = 1'b0.
  - Reused by the transmitter and the mixer.
- One sub-module: i2s_input_sync. It holds the SYNC_STAGES synchronizers for the 3 inputs and the bclk rising-edge detector, and outputs bclk_rise, lrclk_s and din_s.
- The top level contains the bit counter, the channel shifters, frame finalize logic and the output register/handshake (about 200 lines).

Test Plan:
- Reset: assert rst for 3 cycles with the bus toggling → all outputs 0. Set locked=0 and drive one full frame → no sample_valid.
- Basic frame: bclk = clk/8, sample_ready=1. After lock, send left 0x1234, right 0xABCD in 16-bit slots → one sample_valid pulse with left_sample=0x1234, right_sample=0xABCD, latency SYNC_STAGES+2 = 4 cycles after the boundary bclk rise.
- Backpressure: sample_ready=0. Send frames (0x1111,0x2222) then (0x3333,0x4444) → outputs hold 0x1111/0x2222, with exactly one overrun pulse at the second boundary. Raise ready → one transfer, then valid=0.
- Long slots: 24-bit slots carrying left 0x123456, right 0xFEDCBA → output 0x1234 / 0xFEDC.
- Short slots: 8-bit slots carrying left 0xA5, right 0x3C → output 0xA500 / 0x3C00.
- Reset mid-frame: assert rst halfway through a left word, then release → the current partial frame is dropped (locked relocks at the next right→left boundary). The following complete frame (0x0F0F,0xF0F0) is emitted intact.
